// File: rtl/dma_ch_arbiter.sv
// dma_ch_arbiter: round-robin arbiter granting one of eight DMA channels.
// A grant lasts until the channel releases, drops its request, or uses up
// QUANTUM beats. It is followed by one dead GAP cycle before re-arbitration.
// 'release' is a reserved word, so that port is named release_req.
module dma_ch_arbiter #(
   parameter int unsigned QUANTUM = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req,
   input  logic       beat,
   input  logic       release_req,
   output logic [7:0] grant,
   output logic [2:0] sel,
   output logic       busy,
   output logic [3:0] beat_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [3:0] QLAST = 4'(QUANTUM - 1);

   state_t     state, state_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic [2:0] sel_nxt;
   logic [7:0] grant_nxt;
   logic       busy_nxt;
   logic [3:0] cnt_nxt;
   logic [2:0] winner;
   logic [2:0] idx;
   logic       found;
   logic       grant_end;

   // Round-robin search starting at ptr; first requesting channel wins
   always_comb begin
      winner = ptr;
      found  = 1'b0;
      idx    = ptr;
      for (int unsigned i = 0; i < 8; i++) begin
         idx = ptr + 3'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // Any of the end conditions collapses into one grant termination
   always_comb begin
      grant_end = release_req | ~req[sel] | (beat & (beat_cnt == QLAST));
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         beat_cnt <= '0;
         ptr      <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         sel      <= sel_nxt;
         busy     <= busy_nxt;
         beat_cnt <= cnt_nxt;
         ptr      <= ptr_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless changed
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      sel_nxt   = sel;
      busy_nxt  = busy;
      cnt_nxt   = beat_cnt;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = GRANT;
               grant_nxt = 8'b1 << winner;
               sel_nxt   = winner;
               busy_nxt  = 1'b1;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            // A beat coinciding with the grant end is still counted
            if (beat && beat_cnt != 4'hF) begin
               cnt_nxt = beat_cnt + 4'd1;
            end
            if (grant_end) begin
               state_nxt = GAP;
               grant_nxt = '0;
               busy_nxt  = 1'b0;
               ptr_nxt   = sel + 3'd1;
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_ch_arbiter.sv
// Directed testbench for dma_ch_arbiter: one instance at the default
// quantum and one with QUANTUM=4 for the beat limit.
module tb_dma_ch_arbiter;

   logic       clk;
   logic       reset;
   logic [7:0] req;
   logic       beat;
   logic       release_req;
   logic [7:0] grant;
   logic [2:0] sel;
   logic       busy;
   logic [3:0] beat_cnt;

   logic [7:0] req4;
   logic       beat4;
   logic       release4;
   logic [7:0] grant4;
   logic [2:0] sel4;
   logic       busy4;
   logic [3:0] beat_cnt4;

   int checks;
   int failures;

   dma_ch_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .beat        (beat),
      .release_req (release_req),
      .grant       (grant),
      .sel         (sel),
      .busy        (busy),
      .beat_cnt    (beat_cnt)
   );

   dma_ch_arbiter #(.QUANTUM(4)) dut_q4 (
      .clk         (clk),
      .reset       (reset),
      .req         (req4),
      .beat        (beat4),
      .release_req (release4),
      .grant       (grant4),
      .sel         (sel4),
      .busy        (busy4),
      .beat_cnt    (beat_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_main(input string tag, input logic [7:0] g, input logic [2:0] s,
                             input logic b, input logic [3:0] c);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".sel"}, 32'(sel), 32'(s));
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".cnt"}, 32'(beat_cnt), 32'(c));
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      req         = 8'hFF;
      beat        = 1'b0;
      release_req = 1'b0;
      req4        = 8'h00;
      beat4       = 1'b0;
      release4    = 1'b0;

      // Reset with all requests active
      repeat (3) tick();
      check_main("rst", 8'h00, 3'd0, 1'b0, 4'd0);
      check("rst.q4grant", 32'(grant4), 32'h0);
      reset = 1'b0;
      tick();
      check_main("first", 8'h01, 3'd0, 1'b1, 4'd0);

      // Full rotation with release one cycle after each grant
      for (int k = 1; k <= 8; k++) begin
         release_req = 1'b1;
         tick();
         release_req = 1'b0;
         check("rot.gap_grant", 32'(grant), 32'h0);
         check("rot.gap_busy", 32'(busy), 32'h0);
         check("rot.gap_sel", 32'(sel), 32'((k - 1) % 8));
         tick();
         check("rot.idle_grant", 32'(grant), 32'h0);
         tick();
         check("rot.grant", 32'(grant), 32'(8'h01 << (k % 8)));
         check("rot.sel", 32'(sel), 32'(k % 8));
      end

      // Count two beats, then beat+release+req drop together at cnt=2
      beat = 1'b1;
      tick();
      tick();
      check_main("cnt2", 8'h01, 3'd0, 1'b1, 4'd2);
      release_req = 1'b1;
      req         = 8'hFE;
      tick();
      beat        = 1'b0;
      release_req = 1'b0;
      req         = 8'hFF;
      check_main("coinc.gap", 8'h00, 3'd0, 1'b0, 4'd3);
      tick();
      check_main("coinc.idle", 8'h00, 3'd0, 1'b0, 4'd3);
      tick();
      check_main("coinc.next", 8'h02, 3'd1, 1'b1, 4'd0);

      // Other channels changing does not disturb the grant; own drop ends it
      req = 8'h02;
      tick();
      check_main("others", 8'h02, 3'd1, 1'b1, 4'd0);
      req = 8'h00;
      tick();
      check_main("drop.gap", 8'h00, 3'd1, 1'b0, 4'd0);
      tick();
      // beat/release while idle have no effect
      beat        = 1'b1;
      release_req = 1'b1;
      tick();
      tick();
      beat        = 1'b0;
      release_req = 1'b0;
      check_main("idle.ign", 8'h00, 3'd1, 1'b0, 4'd0);

      // Pointer wrap from channel 7
      req = 8'h80;
      tick();
      check_main("ch7", 8'h80, 3'd7, 1'b1, 4'd0);
      req         = 8'h81;
      release_req = 1'b1;
      tick();
      release_req = 1'b0;
      tick();
      tick();
      check_main("wrap", 8'h01, 3'd0, 1'b1, 4'd0);

      // Reset mid-grant on channel 5 with six beats counted
      req         = 8'h00;
      release_req = 1'b1;
      tick();
      release_req = 1'b0;
      tick();
      req = 8'h20;
      tick();
      check_main("ch5", 8'h20, 3'd5, 1'b1, 4'd0);
      beat = 1'b1;
      repeat (6) tick();
      check_main("ch5.cnt6", 8'h20, 3'd5, 1'b1, 4'd6);
      reset = 1'b1;
      tick();
      check_main("midrst", 8'h00, 3'd0, 1'b0, 4'd0);
      reset = 1'b0;
      beat  = 1'b0;
      req   = 8'h21;
      tick();
      check_main("postrst", 8'h01, 3'd0, 1'b1, 4'd0);

      // Quantum limit with QUANTUM=4 and a beat every cycle
      req4  = 8'h08;
      beat4 = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("q4.grant", 32'(grant4), 32'h08);
         check("q4.cnt", 32'(beat_cnt4), 32'(i));
         tick();
      end
      check("q4.gap_grant", 32'(grant4), 32'h0);
      check("q4.gap_busy", 32'(busy4), 32'h0);
      check("q4.gap_cnt", 32'(beat_cnt4), 32'd4);
      tick();
      check("q4.idle_grant", 32'(grant4), 32'h0);
      check("q4.idle_cnt", 32'(beat_cnt4), 32'd4);
      tick();
      check("q4.regrant", 32'(grant4), 32'h08);
      check("q4.regrant_sel", 32'(sel4), 32'd3);
      check("q4.regrant_cnt", 32'(beat_cnt4), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dma_ch_arbiter.md
DMA_CH_ARBITER -- requirements
Module: dma_ch_arbiter

Interface
REQ-001 The block SHALL have parameter QUANTUM, default 8, meaning the maximum beats per grant (legal range 1..15).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port req, input, 8 bits: per-channel transfer request; bit k is channel k.
REQ-005 Port beat, input, 1 bit: the DMA engine completed one 32-bit beat for the granted channel.
REQ-006 Port release, input, 1 bit: the granted channel's transfer is finished; end the grant.
REQ-007 Port grant, output, 8 bits: one-hot grant, registered.
REQ-008 Port sel, output, 3 bits: binary index of the granted channel; drives the 8-to-1 datapath mux select, registered.
REQ-009 Port busy, output, 1 bit: high while in GRANT, registered.
REQ-010 Port beat_cnt, output, 4 bits: beats counted in the current grant, registered.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-012 IDLE with req==0: stay in IDLE.
REQ-013 IDLE with req!=0: next edge, select the winner, load grant and sel, clear beat_cnt, and go to GRANT (1-cycle req-to-grant latency).
REQ-014 Winner selection SHALL be round-robin: search indices ptr, ptr+1, ..., ptr+7 mod 8; the first set req bit wins.
REQ-015 In GRANT, beat==1 SHALL increment beat_cnt by 1 (saturating at 15).
REQ-016 In GRANT, the grant SHALL end when any of these holds: release==1, req[sel]==0, or beat==1 with beat_cnt==QUANTUM-1.
REQ-017 On grant end, the next edge SHALL: go to GAP, set grant=0 and busy=0, set ptr=(sel+1) mod 8 (7 wraps to 0), and hold sel at its last value.
REQ-018 GAP SHALL last exactly one cycle and then unconditionally go to IDLE, giving the datapath a dead cycle.
REQ-019 Any combination of release, beat and req drop in the same cycle SHALL produce a single grant end; a coincident beat is still counted into beat_cnt.
REQ-020 In GRANT, changes to req bits other than req[sel] SHALL NOT affect the grant.
REQ-021 beat and release outside GRANT SHALL be ignored, with no state change.
REQ-022 grant SHALL always equal either 0 or the one-hot decode of sel, and SHALL be nonzero only in GRANT.
REQ-023 beat_cnt SHALL hold its value through GAP and IDLE, and clear only on a new grant or reset.

Reset
REQ-024 When reset==1 at a rising edge: state=IDLE, grant=8'h00, sel=3'd0, busy=0, beat_cnt=0, ptr=0.
REQ-025 Reset SHALL override all other inputs, including mid-GRANT, with grant clearing on that same edge.
REQ-026 After reset deasserts, the first arbitration SHALL occur on the next edge at which req!=0.

Verification
REQ-027 Reset with all requests: reset=1, req=8'hFF for 3 cycles -> grant=0, sel=0, busy=0; first edge after reset drops -> grant=8'h01, sel=0, busy=1.
REQ-028 Full rotation: req=8'hFF constant, release pulsed 1 cycle after each grant -> grants ch0,1,2,...,7,0 in order, each separated by a GAP cycle and an IDLE cycle.
REQ-029 Quantum limit: QUANTUM=4, req=8'h08 held, beat=1 every cycle -> grant=8'h08 for exactly 4 cycles, beat_cnt=4; then GAP and IDLE; then ch3 regranted with beat_cnt=0.
REQ-030 Pointer wrap: ch7 released while req=8'b1000_0001 -> next grant=8'h01, sel=0.
REQ-031 Coincident events: beat=1, release=1 and req[sel]=0 in one cycle with beat_cnt=2 -> beat_cnt=3, a single transition to GAP, and ptr advanced by exactly one.
REQ-032 Reset mid-grant: reset=1 while granted to ch5 with beat_cnt=6 -> next edge grant=0, sel=0, beat_cnt=0, ptr=0; then with req=8'h21, ch0 wins.
